regbank_wr_ctrl: RTL and testbench

Write-port controller for the 32 x 32-bit register bank. Shares the bank's single write port (write, dr, wrData) between NREQ requesters using round-robin arbitration with a valid/ready handshake. Provides a sequenced clear that writes zero to every register, one per cycle, with busy/done status. Sits directly in front of the bank: its wr_* outputs drive the bank's write, dr and wrData inputs.

---
 rtl/regbank_ctrl_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/regbank_wr_ctrl.sv | 103 ++++++++++
 tb/tb_regbank_wr_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/regbank_ctrl_pkg.sv
// Shared types and default sizes for the register bank write-port controller.
package regbank_ctrl_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int DEF_AW    = 5;
   localparam int DEF_DW    = 32;
   localparam int DEF_NREGS = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr wins.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int SW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [SW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [SW-1:0]   idx,
   output logic            any
);

   // Scan NREQ positions starting at ptr, wrapping modulo NREQ; first hit wins.
   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any && valid[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = SW'(j);
         end
      end
   end

endmodule

// File: rtl/regbank_wr_ctrl.sv
// Write-port controller for the register bank: round-robin requester writes
// plus a sequenced full-bank clear. All wr_* outputs are registered.
module regbank_wr_ctrl
   import regbank_ctrl_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW,
   parameter int NREGS = DEF_NREGS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*AW-1:0]       req_addr,
   input  logic [NREQ*DW-1:0]       req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     clr_start,
   output logic                     clr_busy,
   output logic                     clr_done,
   output logic                     wr_en,
   output logic [AW-1:0]            wr_addr,
   output logic [DW-1:0]            wr_data,
   output logic [$clog2(NREQ)-1:0]  wr_src
);

   localparam int SW = $clog2(NREQ);

   state_t          state;
   logic [SW-1:0]   ptr;
   logic [AW-1:0]   cnt;

   logic [NREQ-1:0] grant;
   logic [SW-1:0]   gidx;
   logic            gany;
   logic            arb_en;
   logic            hs;
   logic [SW-1:0]   ptr_nxt;

   rr_arbiter #(.NREQ(NREQ), .SW(SW)) u_arb (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   // Requesters are only offered the port in IDLE when no clear is being requested;
   // ready is held low while reset is asserted.
   assign arb_en    = reset && (state == IDLE) && !clr_start;
   assign req_ready = arb_en ? grant : '0;
   assign hs        = arb_en && gany;
   assign ptr_nxt   = (gidx == SW'(NREQ-1)) ? '0 : gidx + 1'b1;

   // Main FSM: registers the winning write in IDLE, walks every register in CLEAR.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_src   <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               clr_done <= 1'b0;
               if (clr_start) begin
                  state    <= CLEAR;
                  cnt      <= '0;
                  wr_en    <= 1'b0;
                  clr_busy <= 1'b1;
               end else if (hs) begin
                  ptr     <= ptr_nxt;
                  wr_en   <= 1'b1;
                  wr_addr <= req_addr[gidx*AW +: AW];
                  wr_data <= req_data[gidx*DW +: DW];
                  wr_src  <= gidx;
               end else begin
                  wr_en <= 1'b0;
               end
            end
            CLEAR: begin
               // clr_start is ignored here; a second clear is never queued
               wr_en   <= 1'b1;
               wr_addr <= cnt;
               wr_data <= '0;
               wr_src  <= '0;
               cnt     <= cnt + 1'b1;
               if (cnt == AW'(NREGS-1)) begin
                  state    <= IDLE;
                  clr_busy <= 1'b0;
                  clr_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regbank_wr_ctrl.sv
// Self-checking bench: behavioural model of arbitration/clear plus bank scoreboard.
module tb_regbank_wr_ctrl;

   localparam int NREQ = 4, AW = 5, DW = 32, NREGS = 32;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                clr_start;
   logic                clr_busy, clr_done, wr_en;
   logic [AW-1:0]       wr_addr;
   logic [DW-1:0]       wr_data;
   logic [1:0]          wr_src;

   regbank_wr_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(NREGS)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .clr_start(clr_start),
      .clr_busy(clr_busy), .clr_done(clr_done), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;

   // behavioural model
   int          m_ptr = 0, m_cidx = 0;
   bit          m_busy = 0;
   logic        m_en = 0, m_cbusy = 0, m_done = 0;
   logic [4:0]  m_addr = 0;
   logic [31:0] m_data = 0;
   logic [1:0]  m_src = 0;
   logic [31:0] ref_bank [NREGS];
   logic [31:0] dut_bank [NREGS];
   logic [3:0]  last_rdy;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pick();
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (m_ptr + k) % NREQ;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_step(input int g);
      if (!reset) begin
         m_ptr = 0; m_cidx = 0; m_busy = 0;
         m_en = 0; m_addr = 0; m_data = 0; m_src = 0; m_cbusy = 0; m_done = 0;
      end else if (m_busy) begin
         m_en = 1; m_addr = 5'(m_cidx); m_data = 0; m_src = 0;
         ref_bank[m_cidx] = 0;
         if (m_cidx == NREGS-1) begin
            m_busy = 0; m_cbusy = 0; m_done = 1;
         end else begin
            m_cidx++; m_done = 0;
         end
      end else begin
         m_done = 0;
         if (clr_start) begin
            m_busy = 1; m_cidx = 0; m_en = 0; m_cbusy = 1;
         end else if (g >= 0) begin
            m_en = 1;
            m_addr = req_addr[g*AW +: AW];
            m_data = req_data[g*DW +: DW];
            m_src = 2'(g);
            ref_bank[m_addr] = m_data;
            m_ptr = (g + 1) % NREQ;
         end else begin
            m_en = 0;
         end
      end
   endtask

   // One clock: check ready against model, advance model at the edge, check outputs.
   task automatic cycle();
      int g;
      logic [3:0] exp_rdy;
      #1;
      g = pick();
      exp_rdy = (!reset || m_busy || clr_start || g < 0) ? 4'b0 : 4'(1 << g);
      check("ready", 64'(req_ready), 64'(exp_rdy));
      last_rdy = req_ready;
      @(posedge clk);
      model_step(g);
      @(negedge clk);
      check("outputs", 64'({wr_en, wr_addr, wr_data, wr_src, clr_busy, clr_done}),
            64'({m_en, m_addr, m_data, m_src, m_cbusy, m_done}));
      if (wr_en) dut_bank[wr_addr] = wr_data;
   endtask

   task automatic rand_cycles(input int n, input bit allow_clr);
      for (int i = 0; i < n; i++) begin
         req_valid = 4'($urandom);
         for (int r = 0; r < NREQ; r++) begin
            req_addr[r*AW +: AW] = 5'($urandom);
            req_data[r*DW +: DW] = $urandom;
         end
         clr_start = allow_clr && ($urandom_range(0, 39) == 0);
         cycle();
      end
      clr_start = 0;
   endtask

   task automatic compare_banks(input string name);
      for (int i = 0; i < NREGS; i++) check(name, 64'(dut_bank[i]), 64'(ref_bank[i]));
   endtask

   initial begin
      int done_cnt;
      int guard;
      for (int i = 0; i < NREGS; i++) begin ref_bank[i] = 0; dut_bank[i] = 0; end
      reset = 0; req_valid = 0; req_addr = 0; req_data = 0; clr_start = 0;

      // reset state
      repeat (3) cycle();
      check("reset_outs", 64'({wr_en, wr_addr, wr_data, wr_src, clr_busy, clr_done}), 64'd0);
      check("reset_ready", 64'(req_ready), 64'd0);
      reset = 1;

      // single requester 2
      req_valid = 4'b0100;
      req_addr[2*AW +: AW] = 5'd7;
      req_data[2*DW +: DW] = 32'hDEADBEEF;
      cycle();
      check("single_ready", 64'(last_rdy), 64'b0100);
      check("single_wr", 64'({wr_en, wr_addr, wr_data, wr_src}), 64'({1'b1, 5'd7, 32'hDEADBEEF, 2'd2}));
      // pointer now 3: with 0,1,3 valid, 3 must win
      req_valid = 4'b1011;
      cycle();
      check("ptr_after_2", 64'(last_rdy), 64'b1000);
      req_valid = 0;
      cycle();
      check("idle_no_wr", 64'(wr_en), 64'd0);

      // all four valid from reset: strict rotation
      reset = 0; cycle(); reset = 1;
      req_valid = 4'b1111;
      for (int r = 0; r < NREQ; r++) begin
         req_addr[r*AW +: AW] = 5'(r + 10);
         req_data[r*DW +: DW] = 32'hA000_0000 + r;
      end
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("rr_order", 64'({wr_en, wr_src}), 64'({1'b1, 2'(i % 4)}));
      end

      // clear with all requesters valid; second clr_start mid-clear ignored
      clr_start = 1;
      cycle();
      check("clr_start_ready", 64'(last_rdy), 64'd0);
      check("clr_busy_on", 64'({clr_busy, wr_en}), 64'b10);
      done_cnt = 0;
      for (int k = 0; k < NREGS; k++) begin
         clr_start = (k == 9);
         cycle();
         check("clr_write", 64'({wr_en, wr_addr, wr_data}), 64'({1'b1, 5'(k), 32'h0}));
         if (clr_done) done_cnt++;
      end
      clr_start = 0;
      check("clr_done_last", 64'({clr_done, clr_busy}), 64'b10);
      check("clr_done_count", 64'(done_cnt), 64'd1);
      for (int i = 0; i < NREGS; i++) check("bank_cleared", 64'(dut_bank[i]), 64'd0);
      #1 check("resume_ready", 64'(req_ready), 64'b0001);
      cycle();
      check("resume_wr", 64'({wr_en, wr_src, clr_done}), 64'({1'b1, 2'd0, 1'b0}));

      // reset mid-clear aborts; following clear restarts at 0
      req_valid = 0;
      clr_start = 1; cycle(); clr_start = 0;
      guard = 0;
      while (!(wr_en && wr_addr == 5'd15) && guard < 40) begin cycle(); guard++; end
      check("reach_addr15", 64'(guard < 40), 64'd1);
      reset = 0; cycle();
      check("abort_outs", 64'({wr_en, wr_addr, wr_data, wr_src, clr_busy, clr_done}), 64'd0);
      reset = 1;
      clr_start = 1; cycle(); clr_start = 0;
      cycle();
      check("restart_addr0", 64'({wr_en, wr_addr, clr_busy}), 64'({1'b1, 5'd0, 1'b1}));
      repeat (NREGS) cycle();

      // random traffic with occasional clears, then a clean clear, then more traffic
      rand_cycles(400, 1'b1);
      while (m_busy) cycle();
      req_valid = 0;
      clr_start = 1; cycle(); clr_start = 0;
      repeat (NREGS) cycle();
      compare_banks("bank_after_clr");
      rand_cycles(150, 1'b0);
      req_valid = 0;
      cycle();
      compare_banks("bank_final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
